// File: rtl/mrd_pkg.sv
// Shared definitions for the memory line-read responder.
// Holds the FSM state encoding, requester identifiers, line geometry and a helper that
// forms the byte address of one beat within a line.
package mrd_pkg;

  localparam int unsigned MRD_BEATS  = 4;
  localparam int unsigned MRD_BEAT_W = 32;
  localparam int unsigned MRD_LINE_W = 128;

  typedef enum logic [2:0] {
    MRD_IDLE  = 3'd0,
    MRD_ISSUE = 3'd1,
    MRD_DRAIN = 3'd2,
    MRD_RESP  = 3'd3,
    MRD_FIN   = 3'd4
  } mrd_state_e;

  // Requester identity, used for both the current grant and the round-robin history.
  typedef enum logic {
    MRD_REQ_IC = 1'b0,
    MRD_REQ_DC = 1'b1
  } mrd_req_e;

  // Byte address of beat 'beat' of the line whose upper address bits are 'line_addr'.
  function automatic logic [31:0] mrd_beat_addr(input logic [27:0] line_addr,
                                                input logic [1:0]  beat);
    return {line_addr, beat, 2'b00};
  endfunction

endpackage

// File: rtl/mrd_line_asm.sv
// Line assembly for the memory line-read responder.
// Tracks issued beats through an MLAT-deep valid shift register and writes each returning
// beat into the next 32-bit lane of the line register.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   beat_issue   in   a memory read beat is issued this cycle
//   mem_rdata    in   memory read data, valid MLAT cycles after the issue
//   rdat_m_data  out  assembled 128-bit line (lane k = beat k)
//   last_beat    out  beat 3 of the line is being captured this cycle
module mrd_line_asm
  import mrd_pkg::*;
#(
  parameter int unsigned MLAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  beat_issue,
  input  logic [MRD_BEAT_W-1:0] mem_rdata,
  output logic [MRD_LINE_W-1:0] rdat_m_data,
  output logic                  last_beat
);

  logic [MLAT-1:0] vld_q, vld_d;
  logic [1:0]      cap_cnt_q, cap_cnt_d;
  logic [MRD_BEATS-1:0][MRD_BEAT_W-1:0] line_q, line_d;
  logic            beat_due;

  // The oldest tap of the shift register marks the cycle in which mem_rdata carries a
  // tracked beat; any other cycle's read data is ignored.
  assign beat_due  = vld_q[MLAT-1];
  assign last_beat = beat_due && (cap_cnt_q == 2'd3);

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = beat_issue;
    for (int i = 1; i < int'(MLAT); i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Beats return in issue order, so a wrapping counter names the lane. Lanes are never
  // cleared between transfers; beat 0 of the next line simply overwrites lane 0.
  always_comb begin
    line_d    = line_q;
    cap_cnt_d = cap_cnt_q;
    if (beat_due) begin
      line_d[cap_cnt_q] = mem_rdata;
      cap_cnt_d         = cap_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      cap_cnt_q <= 2'd0;
      line_q    <= '0;
    end else begin
      vld_q     <= vld_d;
      cap_cnt_q <= cap_cnt_d;
      line_q    <= line_d;
    end
  end

  assign rdat_m_data = line_q;

endmodule

// File: rtl/mem_rd_responder.sv
// Responder for instruction- and data-cache line fills.
// Latches one pending start per requester, arbitrates round-robin, issues four sequential
// 32-bit reads on a fixed-latency memory port, and returns the assembled line with a
// one-cycle valid pulse followed by a one-cycle finish pulse to the granted requester.
//
// Ports:
//   clk, rst_n                        clock and asynchronous active-low reset
//   icr_start_rq / ic_rin_addr        IC start pulse and line byte address
//   dcr_start_rq / dc_rin_addr        DC start pulse and line byte address
//   rdat_m_data                       assembled line, shared by both requesters
//   ic_rdat_m_valid / dc_rdat_m_valid line-valid pulse per requester
//   ic_finish_mrd / dc_finish_mrd     transfer-finished pulse per requester
//   mem_ren / mem_radr / mem_rdata    fixed-latency memory read port
module mem_rd_responder
  import mrd_pkg::*;
#(
  parameter int unsigned MLAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icr_start_rq,
  input  logic [31:0]           ic_rin_addr,
  input  logic                  dcr_start_rq,
  input  logic [31:0]           dc_rin_addr,
  output logic [MRD_LINE_W-1:0] rdat_m_data,
  output logic                  ic_rdat_m_valid,
  output logic                  dc_rdat_m_valid,
  output logic                  ic_finish_mrd,
  output logic                  dc_finish_mrd,
  output logic                  mem_ren,
  output logic [31:0]           mem_radr,
  input  logic [MRD_BEAT_W-1:0] mem_rdata
);

  // Byte-within-line bits are never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_rin_addr[3:0], dc_rin_addr[3:0]};

  mrd_state_e  state_q, state_d;
  mrd_req_e    gnt_q, gnt_d;
  mrd_req_e    last_gnt_q, last_gnt_d;
  mrd_req_e    pick;
  logic [27:0] xfer_addr_q, xfer_addr_d;
  logic [1:0]  iss_cnt_q, iss_cnt_d;

  logic        ic_pend_q, ic_pend_d;
  logic        dc_pend_q, dc_pend_d;
  logic [27:0] ic_addr_q, ic_addr_d;
  logic [27:0] dc_addr_q, dc_addr_d;
  logic        grant_ic, grant_dc;
  logic        last_beat;

  // Request latches. A start arriving in the same cycle as that requester's grant is kept
  // as a fresh request; otherwise a start while pending is dropped and the first address
  // is kept.
  always_comb begin
    ic_pend_d = ic_pend_q;
    ic_addr_d = ic_addr_q;
    if (grant_ic) begin
      ic_pend_d = 1'b0;
    end
    if (icr_start_rq && (!ic_pend_q || grant_ic)) begin
      ic_pend_d = 1'b1;
      ic_addr_d = ic_rin_addr[31:4];
    end
  end

  always_comb begin
    dc_pend_d = dc_pend_q;
    dc_addr_d = dc_addr_q;
    if (grant_dc) begin
      dc_pend_d = 1'b0;
    end
    if (dcr_start_rq && (!dc_pend_q || grant_dc)) begin
      dc_pend_d = 1'b1;
      dc_addr_d = dc_rin_addr[31:4];
    end
  end

  // Round-robin on a tie: the requester not granted last wins.
  always_comb begin
    if (ic_pend_q && dc_pend_q) begin
      pick = (last_gnt_q == MRD_REQ_IC) ? MRD_REQ_DC : MRD_REQ_IC;
    end else if (dc_pend_q) begin
      pick = MRD_REQ_DC;
    end else begin
      pick = MRD_REQ_IC;
    end
  end

  // Transfer FSM: next state and all outputs decoded from registered state.
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    last_gnt_d      = last_gnt_q;
    xfer_addr_d     = xfer_addr_q;
    iss_cnt_d       = iss_cnt_q;
    grant_ic        = 1'b0;
    grant_dc        = 1'b0;
    mem_ren         = 1'b0;
    mem_radr        = 32'd0;
    ic_rdat_m_valid = 1'b0;
    dc_rdat_m_valid = 1'b0;
    ic_finish_mrd   = 1'b0;
    dc_finish_mrd   = 1'b0;

    unique case (state_q)
      MRD_IDLE: begin
        if (ic_pend_q || dc_pend_q) begin
          gnt_d       = pick;
          last_gnt_d  = pick;
          grant_ic    = (pick == MRD_REQ_IC);
          grant_dc    = (pick == MRD_REQ_DC);
          xfer_addr_d = (pick == MRD_REQ_DC) ? dc_addr_q : ic_addr_q;
          iss_cnt_d   = 2'd0;
          state_d     = MRD_ISSUE;
        end
      end
      MRD_ISSUE: begin
        mem_ren   = 1'b1;
        mem_radr  = mrd_beat_addr(xfer_addr_q, iss_cnt_q);
        iss_cnt_d = iss_cnt_q + 2'd1;
        if (iss_cnt_q == 2'd3) begin
          state_d = MRD_DRAIN;
        end
      end
      MRD_DRAIN: begin
        // Beat 3 lands in the line register at the end of this cycle.
        if (last_beat) begin
          state_d = MRD_RESP;
        end
      end
      MRD_RESP: begin
        ic_rdat_m_valid = (gnt_q == MRD_REQ_IC);
        dc_rdat_m_valid = (gnt_q == MRD_REQ_DC);
        state_d         = MRD_FIN;
      end
      MRD_FIN: begin
        ic_finish_mrd = (gnt_q == MRD_REQ_IC);
        dc_finish_mrd = (gnt_q == MRD_REQ_DC);
        state_d       = MRD_IDLE;
      end
      default: begin
        state_d = MRD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MRD_IDLE;
      gnt_q       <= MRD_REQ_IC;
      last_gnt_q  <= MRD_REQ_IC;
      xfer_addr_q <= '0;
      iss_cnt_q   <= 2'd0;
      ic_pend_q   <= 1'b0;
      dc_pend_q   <= 1'b0;
      ic_addr_q   <= '0;
      dc_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      xfer_addr_q <= xfer_addr_d;
      iss_cnt_q   <= iss_cnt_d;
      ic_pend_q   <= ic_pend_d;
      dc_pend_q   <= dc_pend_d;
      ic_addr_q   <= ic_addr_d;
      dc_addr_q   <= dc_addr_d;
    end
  end

  mrd_line_asm #(
    .MLAT (MLAT)
  ) u_line_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .beat_issue  (mem_ren),
    .mem_rdata   (mem_rdata),
    .rdat_m_data (rdat_m_data),
    .last_beat   (last_beat)
  );

endmodule
